op_scheduler: RTL and testbench

OP_SCHEDULER -- requirements
Module: op_scheduler

---
 rtl/Op_PKG.sv | 37 +++
 rtl/op_fifo.sv | 67 ++++++
 rtl/op_scheduler.sv | 117 +++++++++++
 tb/tb_op_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/Op_PKG.sv
// Shared op payload, command codes and scheduler state encoding for the op
// scheduler and its FIFO.
package Op_PKG;

  localparam logic [3:0] OP_CMD_G00 = 4'd0;
  localparam logic [3:0] OP_CMD_G01 = 4'd1;
  localparam logic [3:0] OP_CMD_G02 = 4'd2;
  localparam logic [3:0] OP_CMD_G03 = 4'd3;

  typedef struct packed {
    logic [3:0]         cmd;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] i;
    logic signed [15:0] j;
  } Op_st;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ISSUE       = 2'd1,
    S_WAIT_ACCEPT = 2'd2,
    S_WAIT_DONE   = 2'd3
  } OpSchedState_e;

  function automatic Op_st op_make(logic [3:0] cmd, logic signed [15:0] x,
                                   logic signed [15:0] y, logic signed [15:0] i,
                                   logic signed [15:0] j);
    Op_st o;
    o.cmd = cmd;
    o.x   = x;
    o.y   = y;
    o.i   = i;
    o.j   = j;
    return o;
  endfunction

endpackage

// File: rtl/op_fifo.sv
// Circular FIFO of op payloads. Flush can optionally keep the head entry so an
// op already handed to the processor survives the discard.
module op_fifo
  import Op_PKG::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = Op_st
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   flush_keep_head,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop, keep;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign keep    = flush_keep_head & ~do_pop & ~empty;

  // On flush the write pointer collapses onto the (post-pop) read pointer,
  // optionally leaving the head entry in place.
  always_comb begin
    rd_d  = rd_q + AW'(do_pop);
    wr_d  = wr_q + AW'(do_push);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_d  = rd_d + AW'(keep);
      cnt_d = CW'(keep);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clk_en) begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/op_scheduler.sv
// Queues ops from the parser and hands them one at a time to the processor.
// Optional accept timeout enabled with OP_SCHEDULER_TIMEOUT_EN.
module op_scheduler
  import Op_PKG::*;
#(
  parameter int DEPTH          = 4,
  parameter int ACCEPT_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  Op_st                   op_in,
  input  logic                   op_in_valid,
  output logic                   op_in_rdy,
  output Op_st                   op_out,
  output logic                   trigger,
  input  logic                   proc_rdy,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   idle,
  output logic                   timeout_err
);

  OpSchedState_e state_q, state_d;
  Op_st          op_out_q, fifo_head;
  logic          fifo_full, fifo_empty, fifo_pop, in_flight;
  logic          load, tmo_expired, tmo_hit;

  // Only ops past the issue cycle are protected from flush.
  assign in_flight = (state_q == S_WAIT_ACCEPT) || (state_q == S_WAIT_DONE);

  op_fifo #(.DEPTH(DEPTH), .T(Op_st)) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .clk_en          (clk_en),
    .push            (op_in_valid),
    .pop             (fifo_pop),
    .flush           (flush),
    .flush_keep_head (in_flight),
    .din             (op_in),
    .dout            (fifo_head),
    .full            (fifo_full),
    .empty           (fifo_empty),
    .count           (queue_count)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty && proc_rdy && !flush) begin
        state_d = S_ISSUE;
        load    = 1'b1;
      end
      S_ISSUE: state_d = flush ? S_IDLE : S_WAIT_ACCEPT;
      S_WAIT_ACCEPT: begin
        if (!proc_rdy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_expired) begin
          state_d  = S_IDLE;
          fifo_pop = 1'b1;
          tmo_hit  = 1'b1;
        end
      end
      S_WAIT_DONE: if (proc_rdy) begin
        state_d  = S_IDLE;
        fifo_pop = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_out_q <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      if (load) op_out_q <= fifo_head;
    end
  end

`ifdef OP_SCHEDULER_TIMEOUT_EN
  localparam int TW = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_err_q;

  // Counter is zero in the issue cycle, so expiry lands ACCEPT_TIMEOUT cycles after trigger rises.
  assign tmo_expired = (tmo_cnt_q == TW'(ACCEPT_TIMEOUT - 1));
  assign tmo_cnt_d   = ((state_q == S_ISSUE) || (state_q == S_WAIT_ACCEPT)) ?
                       tmo_cnt_q + TW'(1) : '0;
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else if (clk_en) begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= tmo_hit;
    end
  end
`else
  logic unused_tmo;
  assign tmo_expired = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_tmo  = tmo_hit ^ (^ACCEPT_TIMEOUT);
`endif

  assign op_out    = op_out_q;
  assign trigger   = (state_q == S_ISSUE) || (state_q == S_WAIT_ACCEPT);
  assign idle      = (state_q == S_IDLE) && fifo_empty;
  assign op_in_rdy = ~fifo_full;

endmodule

// File: tb/tb_op_scheduler.sv
// Self-checking bench for op_scheduler: queue-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_op_scheduler;
  import Op_PKG::*;

  localparam int DEPTH = 4;
  localparam int TO    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef OP_SCHEDULER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int P_FORCE = 0, P_MODEL = 1, P_RAND = 2;

  logic clk = 1'b0;
  logic reset, clk_en, op_in_valid, op_in_rdy, trigger, proc_rdy, flush, idle, timeout_err;
  Op_st op_in, op_out;
  logic [CW-1:0] queue_count;

  op_scheduler #(.DEPTH(DEPTH), .ACCEPT_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .op_in(op_in), .op_in_valid(op_in_valid),
    .op_in_rdy(op_in_rdy), .op_out(op_out), .trigger(trigger), .proc_rdy(proc_rdy),
    .flush(flush), .queue_count(queue_count), .idle(idle), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic Op_st rand_op();
    return op_make(4'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom));
  endfunction

  // ---------------- reference model: a queue plus the issued op's progress
  Op_st mq[$];
  bit   m_busy, m_acc, m_pop, m_tmo, inflight, chk_on;
  int   m_age, n0;
  Op_st m_out;

  initial begin
    m_busy = 0; m_acc = 0; m_age = 0; m_out = '0; m_tmo = 0; chk_on = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete(); m_busy = 0; m_acc = 0; m_age = 0; m_out = '0; m_tmo = 0;
      end else if (clk_en) begin
        n0 = mq.size();
        inflight = m_busy && (m_acc || m_age > 0);
        m_pop = 0; m_tmo = 0;
        if (!m_busy) begin
          if (n0 > 0 && proc_rdy && !flush) begin
            m_busy = 1; m_acc = 0; m_age = 0; m_out = mq[0];
          end
        end else if (!m_acc && m_age == 0) begin
          if (flush) m_busy = 0; else m_age = 1;
        end else if (!m_acc) begin
          if (!proc_rdy) m_acc = 1;
          else if (TMO_EN && m_age == TO - 1) begin m_pop = 1; m_busy = 0; m_tmo = 1; end
          else m_age++;
        end else if (proc_rdy) begin
          m_pop = 1; m_busy = 0;
        end
        if (m_pop) void'(mq.pop_front());
        if (flush) begin
          if (inflight && !m_pop) begin
            while (mq.size() > 1) void'(mq.pop_back());
          end else mq.delete();
        end else if (op_in_valid && n0 < DEPTH) mq.push_back(op_in);
      end
    end
  end

  // ---------------- per-cycle compare
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("count", queue_count, mq.size());
      chk("idle", idle, (!m_busy && mq.size() == 0));
      chk("op_in_rdy", op_in_rdy, (mq.size() < DEPTH));
      chk("trigger", trigger, (m_busy && !m_acc));
      chk("op_out", op_out, m_out);
      chk("timeout_err", timeout_err, m_tmo);
    end
  end

  // ---------------- trigger log
  Op_st trig_log[$];
  int   trig_cnt = 0;
  bit   trig_prev = 0;
  initial forever begin
    @(negedge clk);
    if (trigger && !trig_prev) begin trig_log.push_back(op_out); trig_cnt++; end
    trig_prev = trigger;
  end

  // ---------------- processor model
  int pmode = P_FORCE, p_lat = 2, p_busy = 10, wait_c = 0, busy_c = 0;
  bit proc_force = 1, trig_s;
  initial begin
    proc_rdy = 1'b1;
    forever begin
      @(negedge clk); trig_s = trigger;
      @(posedge clk); #2;
      case (pmode)
        P_FORCE: begin proc_rdy = proc_force; wait_c = 0; end
        P_MODEL: if (proc_rdy) begin
          if (trig_s) begin
            wait_c++;
            if (wait_c >= p_lat) begin proc_rdy = 1'b0; busy_c = p_busy; wait_c = 0; end
          end else wait_c = 0;
        end else begin
          if (busy_c > 0) busy_c--;
          if (busy_c == 0) proc_rdy = 1'b1;
        end
        default: begin proc_rdy = ($urandom_range(0, 3) != 0); wait_c = 0; end
      endcase
    end
  end

  // ---------------- upstream parser: offers up_q head until taken
  Op_st up_q[$];
  bit   up_hold = 0, will_push;
  initial begin
    op_in_valid = 1'b0; op_in = '0;
    forever begin
      @(negedge clk);
      will_push = op_in_valid && op_in_rdy && clk_en && !flush && !reset;
      @(posedge clk); #2;
      if (will_push) void'(up_q.pop_front());
      if (up_q.size() > 0 && !up_hold) begin op_in_valid = 1'b1; op_in = up_q[0]; end
      else op_in_valid = 1'b0;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int   base, bl, k;
  Op_st exp_ops[$];
  Op_st op_a, op_b, op_c;

  initial begin
    reset = 1; clk_en = 1; flush = 0;
    step(1); chk_on = 1;
    step(2); reset = 0; step(1);
    chk("rst_count", queue_count, 0);
    chk("rst_idle", idle, 1);
    chk("rst_rdy", op_in_rdy, 1);
    chk("rst_trigger", trigger, 0);
    chk("rst_op_out", op_out, 0);
    chk("rst_tmo", timeout_err, 0);

    // three ops through a latency-2 / busy-10 processor
    pmode = P_MODEL; p_lat = 2; p_busy = 10;
    base = trig_cnt; bl = trig_log.size();
    up_q.push_back(op_make(OP_CMD_G00, 16'sd100, 16'sd100, 16'sd0, 16'sd0));
    up_q.push_back(op_make(OP_CMD_G01, 16'sd120, 16'sd100, 16'sd0, 16'sd0));
    up_q.push_back(op_make(OP_CMD_G02, 16'sd100, 16'sd100, 16'sd0, -16'sd20));
    for (k = 0; k < 400 && !(trig_cnt == base + 3 && idle && proc_rdy); k++) step();
    chk("A_triggers", trig_cnt - base, 3);
    chk("A_idle", idle, 1);
    chk("A_op0", (trig_log.size() > bl) ? trig_log[bl] : '0,
        {4'd0, 16'sd100, 16'sd100, 16'sd0, 16'sd0});
    chk("A_op1", (trig_log.size() > bl + 1) ? trig_log[bl + 1] : '0,
        {4'd1, 16'sd120, 16'sd100, 16'sd0, 16'sd0});
    chk("A_op2", (trig_log.size() > bl + 2) ? trig_log[bl + 2] : '0,
        {4'd2, 16'sd100, 16'sd100, 16'sd0, -16'sd20});

    // DEPTH+1 ops with the processor stuck busy
    pmode = P_FORCE; proc_force = 0; step(2);
    base = trig_cnt; bl = trig_log.size(); exp_ops.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin op_a = rand_op(); exp_ops.push_back(op_a); up_q.push_back(op_a); end
    step(DEPTH + 4);
    chk("B_count_full", queue_count, DEPTH);
    chk("B_rdy_low", op_in_rdy, 0);
    chk("B_no_trigger", trig_cnt - base, 0);
    chk("B_held", up_q.size(), 1);
    pmode = P_MODEL; p_lat = 2; p_busy = 4;
    for (k = 0; k < 200 && up_q.size() != 0; k++) step();
    chk("B_last_taken", up_q.size(), 0);
    chk("B_count_after", queue_count, DEPTH);
    for (k = 0; k < 400 && !(trig_cnt == base + DEPTH + 1 && idle && proc_rdy); k++) step();
    chk("B_triggers", trig_cnt - base, DEPTH + 1);
    for (int i = 0; i < DEPTH + 1; i++)
      chk("B_order", (trig_log.size() > bl + i) ? trig_log[bl + i] : '0, exp_ops[i]);

    // flush while the first op is waiting for completion
    pmode = P_FORCE; proc_force = 0; step(2);
    for (int i = 0; i < 4; i++) up_q.push_back(rand_op());
    step(6);
    chk("C_count4", queue_count, 4);
    base = trig_cnt;
    pmode = P_MODEL; p_lat = 1; p_busy = 15;
    for (k = 0; k < 50 && !(trig_cnt > base && !trigger); k++) step();
    flush = 1; step(); flush = 0;
    chk("C_inflight_kept", queue_count, 1);
    for (k = 0; k < 60 && !idle; k++) step();
    chk("C_count0", queue_count, 0);
    step(20);
    chk("C_no_more_trig", trig_cnt - base, 1);

    // push and pop on the same edge at count 2
    pmode = P_FORCE; proc_force = 0; step(2);
    op_a = rand_op(); op_b = rand_op(); op_c = rand_op();
    up_q.push_back(op_a); up_q.push_back(op_b);
    step(4);
    chk("D_count2", queue_count, 2);
    up_hold = 1; up_q.push_back(op_c);
    base = trig_cnt; bl = trig_log.size();
    proc_force = 1; step();
    proc_force = 0; step(3);
    proc_force = 1; up_hold = 0; step(2);
    chk("D_count_stays", queue_count, 2);
    pmode = P_MODEL; p_lat = 1; p_busy = 2;
    for (k = 0; k < 200 && !(trig_cnt == base + 3 && idle && proc_rdy); k++) step();
    chk("D_triggers", trig_cnt - base, 3);
    chk("D_order0", (trig_log.size() > bl) ? trig_log[bl] : '0, op_a);
    chk("D_order1", (trig_log.size() > bl + 1) ? trig_log[bl + 1] : '0, op_b);
    chk("D_order2", (trig_log.size() > bl + 2) ? trig_log[bl + 2] : '0, op_c);

    // reset while waiting for acceptance
    pmode = P_FORCE; proc_force = 1; step(2);
    up_q.push_back(rand_op());
    for (k = 0; k < 20 && !trigger; k++) step();
    step();
    chk("E_pre_trigger", trigger, 1);
    reset = 1; step(); reset = 0;
    chk("E_trigger", trigger, 0);
    chk("E_count", queue_count, 0);
    chk("E_idle", idle, 1);

`ifdef OP_SCHEDULER_TIMEOUT_EN
    // processor never accepts: one timeout pulse, then the next op issues
    up_q.push_back(rand_op()); up_q.push_back(rand_op());
    for (k = 0; k < 20 && !trigger; k++) step();
    for (k = 0; k < 20 && !timeout_err; k++) step();
    chk("F_tmo_cycle", k, TO);
    chk("F_trig_dropped", trigger, 0);
    chk("F_count", queue_count, 1);
    step();
    chk("F_tmo_once", timeout_err, 0);
    chk("F_next_issue", trigger, 1);
    pmode = P_MODEL; p_lat = 1; p_busy = 2;
    for (k = 0; k < 200 && !idle; k++) step();
`endif

    // random traffic
    pmode = P_RAND;
    for (int c = 0; c < 3000; c++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 49) == 0);
      reset  = ($urandom_range(0, 399) == 0);
      if (up_q.size() < 3 && $urandom_range(0, 1) == 1) up_q.push_back(rand_op());
      step();
    end
    clk_en = 1; flush = 0; reset = 0;
    pmode = P_MODEL; p_lat = 1; p_busy = 3;
    for (k = 0; k < 1000 && !(idle && up_q.size() == 0); k++) step();
    chk("drain_idle", idle, 1);
    chk("drain_count", queue_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
